// File: rtl/traffic_conflict_monitor_if.sv
// Light-code inputs from the controller and lamp/fault outputs to the heads.
// master drives codes and watches lamps; slave is the safety monitor.
interface traffic_conflict_monitor_if;
    logic [1:0] NS_IN;
    logic [1:0] SN_IN;
    logic [1:0] EW_IN;
    logic [1:0] WE_IN;
    logic [2:0] NS_LAMP;
    logic [2:0] SN_LAMP;
    logic [2:0] EW_LAMP;
    logic [2:0] WE_LAMP;
    logic       FAULT;
    logic [2:0] FAULT_CODE;
    logic       MON_ACTIVE;

    modport master (
        output NS_IN, SN_IN, EW_IN, WE_IN,
        input  NS_LAMP, SN_LAMP, EW_LAMP, WE_LAMP, FAULT, FAULT_CODE, MON_ACTIVE
    );

    modport slave (
        input  NS_IN, SN_IN, EW_IN, WE_IN,
        output NS_LAMP, SN_LAMP, EW_LAMP, WE_LAMP, FAULT, FAULT_CODE, MON_ACTIVE
    );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between light controller and lamp heads: legal codes reach the lamps
// one cycle later; any violation latches a fault code and flashes red until CLEAR (no backpressure).
module traffic_conflict_monitor #(
    parameter int STARTUP_CYCLES = 4,
    parameter int MIN_YELLOW     = 3,
    parameter int ALLRED_MAX     = 4,
    parameter int FLASH_HALF     = 8
) (
    input logic                       CLK,
    input logic                       CLEAR,
    traffic_conflict_monitor_if.slave bus
);
    localparam int IW = $clog2(STARTUP_CYCLES + 1);
    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int AW = $clog2(ALLRED_MAX + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);

    localparam logic [1:0] C_RED = 2'b00;
    localparam logic [1:0] C_YEL = 2'b01;
    localparam logic [1:0] C_GRN = 2'b10;
    localparam logic [1:0] C_ILL = 2'b11;

    localparam logic [2:0] L_RED  = 3'b100;
    localparam logic [2:0] L_YEL  = 3'b010;
    localparam logic [2:0] L_GRN  = 3'b001;
    localparam logic [2:0] L_DARK = 3'b000;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FLASH   = 2'd2
    } state_t;

    state_t          state_q;
    logic [2:0]      lamp_q   [4];
    logic [1:0]      prev_q   [4];
    logic [YW-1:0]   ydwell_q [4];
    logic [YW-1:0]   ydwell_d [4];
    logic [AW-1:0]   allred_q;
    logic [AW-1:0]   allred_d;
    logic [IW-1:0]   init_cnt_q;
    logic [FW-1:0]   flash_cnt_q;
    logic            fault_q;
    logic [2:0]      code_q;
    logic [2:0]      code_d;

    logic [1:0]      code_in  [4];
    logic            any_illegal;
    logic            bad_trans;
    logic            short_yel;
    logic            all_red;
    logic [2:0]      nonred_cnt;

    // Direction order everywhere: 0 NS, 1 SN, 2 EW, 3 WE.
    assign code_in[0] = bus.NS_IN;
    assign code_in[1] = bus.SN_IN;
    assign code_in[2] = bus.EW_IN;
    assign code_in[3] = bus.WE_IN;

    function automatic logic [2:0] decode(input logic [1:0] c);
        case (c)
            C_YEL:   decode = L_YEL;
            C_GRN:   decode = L_GRN;
            default: decode = L_RED;
        endcase
    endfunction

    always_comb begin
        any_illegal = 1'b0;
        bad_trans   = 1'b0;
        short_yel   = 1'b0;
        all_red     = 1'b1;
        nonred_cnt  = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (code_in[i] == C_YEL)
                ydwell_d[i] = (ydwell_q[i] == YW'(MIN_YELLOW)) ? ydwell_q[i] : ydwell_q[i] + 1'b1;
            else
                ydwell_d[i] = '0;
            if (code_in[i] == C_ILL)
                any_illegal = 1'b1;
            if (code_in[i] != C_RED) begin
                all_red    = 1'b0;
                nonred_cnt = nonred_cnt + 3'd1;
            end
            // A previous 11 can only have been tracked during INIT; no rule applies to it.
            if (prev_q[i] != C_ILL) begin
                if ((prev_q[i] == C_GRN && code_in[i] == C_RED) ||
                    (prev_q[i] == C_RED && code_in[i] == C_YEL) ||
                    (prev_q[i] == C_YEL && code_in[i] == C_GRN))
                    bad_trans = 1'b1;
            end
            if (prev_q[i] == C_YEL && code_in[i] == C_RED && ydwell_q[i] < YW'(MIN_YELLOW))
                short_yel = 1'b1;
        end

        if (all_red)
            allred_d = (allred_q == AW'(ALLRED_MAX)) ? allred_q : allred_q + 1'b1;
        else
            allred_d = '0;

        if (any_illegal)                     code_d = 3'd1;
        else if (nonred_cnt > 3'd1)          code_d = 3'd2;
        else if (bad_trans)                  code_d = 3'd3;
        else if (short_yel)                  code_d = 3'd4;
        else if (allred_d == AW'(ALLRED_MAX)) code_d = 3'd5;
        else                                 code_d = 3'd0;
    end

    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            state_q     <= ST_INIT;
            fault_q     <= 1'b0;
            code_q      <= 3'd0;
            allred_q    <= '0;
            init_cnt_q  <= '0;
            flash_cnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                lamp_q[i]   <= L_RED;
                prev_q[i]   <= C_RED;
                ydwell_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_INIT: begin
                    allred_q <= allred_d;
                    for (int i = 0; i < 4; i++) begin
                        prev_q[i]   <= code_in[i];
                        ydwell_q[i] <= ydwell_d[i];
                    end
                    if (init_cnt_q != IW'(STARTUP_CYCLES))
                        init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == IW'(STARTUP_CYCLES - 1))
                        state_q <= ST_MONITOR;
                end
                ST_MONITOR: begin
                    if (code_d != 3'd0) begin
                        state_q     <= ST_FLASH;
                        fault_q     <= 1'b1;
                        code_q      <= code_d;
                        flash_cnt_q <= '0;
                        for (int i = 0; i < 4; i++)
                            lamp_q[i] <= L_RED;
                    end else begin
                        allred_q <= allred_d;
                        for (int i = 0; i < 4; i++) begin
                            lamp_q[i]   <= decode(code_in[i]);
                            prev_q[i]   <= code_in[i];
                            ydwell_q[i] <= ydwell_d[i];
                        end
                    end
                end
                ST_FLASH: begin
                    if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
                        flash_cnt_q <= '0;
                        for (int i = 0; i < 4; i++)
                            lamp_q[i] <= (lamp_q[i] == L_DARK) ? L_RED : L_DARK;
                    end else begin
                        flash_cnt_q <= flash_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign bus.NS_LAMP    = lamp_q[0];
    assign bus.SN_LAMP    = lamp_q[1];
    assign bus.EW_LAMP    = lamp_q[2];
    assign bus.WE_LAMP    = lamp_q[3];
    assign bus.FAULT      = fault_q;
    assign bus.FAULT_CODE = code_q;
    assign bus.MON_ACTIVE = (state_q == ST_MONITOR);
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor: each driven cycle pushes the outputs
// expected after the next edge; a checker pops and compares them just after that edge.
module tb_traffic_conflict_monitor;
    localparam logic [2:0]  LR = 3'b100;
    localparam logic [2:0]  LY = 3'b010;
    localparam logic [2:0]  LG = 3'b001;
    localparam logic [11:0] ALL_R = {LR, LR, LR, LR};
    localparam logic [11:0] ALL_D = 12'h000;
    localparam logic [1:0]  RED = 2'b00;
    localparam logic [1:0]  YEL = 2'b01;
    localparam logic [1:0]  GRN = 2'b10;
    localparam logic [1:0]  ILL = 2'b11;

    typedef struct {
        logic [11:0] lamps;
        logic        fault;
        logic [2:0]  code;
        logic        mon;
        string       tag;
    } exp_t;

    logic CLK;
    logic CLEAR;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    traffic_conflict_monitor_if bus();

    traffic_conflict_monitor dut (
        .CLK  (CLK),
        .CLEAR(CLEAR),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] lamp_of(input logic [1:0] c);
        case (c)
            RED:     lamp_of = LR;
            YEL:     lamp_of = LY;
            GRN:     lamp_of = LG;
            default: lamp_of = 3'b111;
        endcase
    endfunction

    function automatic logic [11:0] lamps_of(input logic [7:0] v);
        lamps_of = {lamp_of(v[7:6]), lamp_of(v[5:4]), lamp_of(v[3:2]), lamp_of(v[1:0])};
    endfunction

    // d: 0 NS, 1 SN, 2 EW, 3 WE; every other direction RED.
    function automatic logic [7:0] one_dir(input int d, input logic [1:0] c);
        logic [7:0] v;
        v = 8'h00;
        v[(7 - 2*d) -: 2] = c;
        return v;
    endfunction

    task automatic step(input logic clr, input logic [7:0] v, input logic [11:0] el,
                        input logic ef, input logic [2:0] ec, input logic em, input string tag);
        exp_t e;
        @(negedge CLK);
        CLEAR = clr;
        {bus.NS_IN, bus.SN_IN, bus.EW_IN, bus.WE_IN} = v;
        e.lamps = el;
        e.fault = ef;
        e.code  = ec;
        e.mon   = em;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic pass(input logic [7:0] v, input string tag);
        step(1'b0, v, lamps_of(v), 1'b0, 3'd0, 1'b1, tag);
    endtask

    task automatic restart(input logic [7:0] v);
        step(1'b1, 8'($urandom), ALL_R, 1'b0, 3'd0, 1'b0, "clear");
        for (int i = 0; i < 4; i++)
            step(1'b0, v, ALL_R, 1'b0, 3'd0, (i == 3), "init");
    endtask

    task automatic phase(input int d, input int g, input int y);
        repeat (g) pass(one_dir(d, GRN), "green");
        repeat (y) pass(one_dir(d, YEL), "yellow");
    endtask

    task automatic full_round();
        phase(0, 6, 3);
        phase(2, 6, 3);
        phase(1, 6, 3);
        phase(3, 6, 3);
    endtask

    task automatic flash_tail(input int n, input logic [2:0] ec);
        for (int i = 1; i <= n; i++)
            step(1'b0, 8'($urandom), ((i / 8) % 2 == 1) ? ALL_D : ALL_R, 1'b1, ec, 1'b0, "flash");
    endtask

    always begin
        exp_t e;
        @(posedge CLK);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({e.tag, ".lamps"}, 32'({bus.NS_LAMP, bus.SN_LAMP, bus.EW_LAMP, bus.WE_LAMP}), 32'(e.lamps));
            check_eq({e.tag, ".fault"}, 32'(bus.FAULT), 32'(e.fault));
            check_eq({e.tag, ".code"},  32'(bus.FAULT_CODE), 32'(e.code));
            check_eq({e.tag, ".mon"},   32'(bus.MON_ACTIVE), 32'(e.mon));
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        CLEAR = 1'b1;
        {bus.NS_IN, bus.SN_IN, bus.EW_IN, bus.WE_IN} = 8'h00;

        // Normal controller cycle, two full rounds.
        restart(one_dir(0, GRN));
        full_round();
        full_round();

        // Conflict, then the full flash pattern.
        pass(one_dir(0, GRN), "pre_conflict");
        step(1'b0, one_dir(0, GRN) | one_dir(2, GRN), ALL_R, 1'b1, 3'd2, 1'b0, "conflict");
        flash_tail(18, 3'd2);

        // CLEAR in the middle of FLASH, then a clean legal round.
        restart(one_dir(0, GRN));
        full_round();

        // Green straight to red.
        phase(0, 3, 0);
        step(1'b0, one_dir(2, GRN), ALL_R, 1'b1, 3'd3, 1'b0, "illegal_trans");
        flash_tail(3, 3'd3);

        // Yellow held only two samples.
        restart(one_dir(0, GRN));
        phase(0, 6, 2);
        step(1'b0, one_dir(2, GRN), ALL_R, 1'b1, 3'd4, 1'b0, "short_yellow");
        flash_tail(2, 3'd4);

        // Yellow held exactly the minimum, then an all-red stall.
        restart(one_dir(0, GRN));
        phase(0, 6, 3);
        pass(one_dir(2, GRN), "min_yellow_ok");
        phase(2, 5, 3);
        repeat (3) pass(8'h00, "allred_ok");
        step(1'b0, 8'h00, ALL_R, 1'b1, 3'd5, 1'b0, "allred_stall");
        flash_tail(2, 3'd5);

        // Illegal code beats conflict.
        restart(one_dir(0, GRN));
        step(1'b0, one_dir(0, ILL) | one_dir(1, GRN) | one_dir(2, GRN), ALL_R, 1'b1, 3'd1, 1'b0, "priority");
        flash_tail(2, 3'd1);

        @(negedge CLK);
        @(negedge CLK);
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
